// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction-memory port,
// and the registered IF/ID and PC state out toward decode.
interface if_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [9:0]  im_addr;
  logic [31:0] im_dout;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  // master: the fetch stage itself
  modport master (
    input  stall, redirect, redirect_target, im_dout,
    output im_addr, pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count
  );

  // slave: hazard unit, ID stage and instruction memory around it
  modport slave (
    output stall, redirect, redirect_target, im_dout,
    input  im_addr, pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory addressing and the
// IF/ID pipeline register, with stall > redirect > sequential priority.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  if_stage_if.master bus
);

  localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_WORD = RESET_PC & ALIGN_MASK;

  logic [31:0] pc_reg,          pc_next;
  logic [31:0] ifid_instr_reg,  ifid_instr_next;
  logic [31:0] ifid_pc4_reg,    ifid_pc4_next;
  logic        ifid_valid_reg,  ifid_valid_next;
  logic [31:0] fetch_count_reg, fetch_count_next;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_reg + 32'd4;

  always_comb begin
    pc_next          = pc_reg;
    ifid_instr_next  = ifid_instr_reg;
    ifid_pc4_next    = ifid_pc4_reg;
    ifid_valid_next  = ifid_valid_reg;
    fetch_count_next = fetch_count_reg;
    if (!bus.stall) begin
      if (bus.redirect) begin
        // Wrong-path instruction at the old pc is dropped as a bubble.
        pc_next         = bus.redirect_target & ALIGN_MASK;
        ifid_instr_next = NOP_INSTR;
        ifid_pc4_next   = 32'd0;
        ifid_valid_next = 1'b0;
      end else begin
        pc_next          = pc_plus4;
        ifid_instr_next  = bus.im_dout;
        ifid_pc4_next    = pc_plus4;
        ifid_valid_next  = 1'b1;
        fetch_count_next = fetch_count_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC_WORD;
      ifid_instr_reg  <= NOP_INSTR;
      ifid_pc4_reg    <= 32'd0;
      ifid_valid_reg  <= 1'b0;
      fetch_count_reg <= 32'd0;
    end else begin
      pc_reg          <= pc_next;
      ifid_instr_reg  <= ifid_instr_next;
      ifid_pc4_reg    <= ifid_pc4_next;
      ifid_valid_reg  <= ifid_valid_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  // Only the word index inside a 4 KB window reaches memory; upper bits alias.
  assign bus.im_addr     = pc_reg[11:2];
  assign bus.pc          = pc_reg;
  assign bus.ifid_instr  = ifid_instr_reg;
  assign bus.ifid_pc4    = ifid_pc4_reg;
  assign bus.ifid_valid  = ifid_valid_reg;
  assign bus.fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a reference PC model pushes expected IF/ID
// entries at drive time and pops them when the stage captures an instruction.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst;
  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign bus.im_dout = mem[bus.im_addr];

  int total = 0;
  int bad   = 0;

  logic [63:0] sb [$];
  logic [31:0] m_pc, m_cnt, e_instr, e_pc4;
  logic        e_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, advance the model, sample 1 ns after the edge.
  task automatic step(input logic s, input logic r, input logic [31:0] tgt, input logic rs);
    logic pop_pending;
    logic [63:0] ent;
    pop_pending = 1'b0;
    @(negedge clk);
    rst = rs; bus.stall = s; bus.redirect = r; bus.redirect_target = tgt;
    if (rs) begin
      m_pc = RESET_PC; m_cnt = 0; sb.delete();
      e_valid = 1'b0; e_instr = 32'd0; e_pc4 = 32'd0;
    end else if (!s) begin
      if (r) begin
        m_pc = {tgt[31:2], 2'b00};
        e_valid = 1'b0; e_instr = 32'd0; e_pc4 = 32'd0;
      end else begin
        sb.push_back({mem[m_pc[11:2]], m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
        pop_pending = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (pop_pending) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL sb_empty observed=%0d expected=%0d", sb.size(), 1);
      end
      if (sb.size() != 0) begin
        ent = sb.pop_front();
        e_instr = ent[63:32]; e_pc4 = ent[31:0]; e_valid = 1'b1;
      end
    end
    chk("pc",          bus.pc,                 m_pc);
    chk("im_addr",     {22'd0, bus.im_addr},   {22'd0, m_pc[11:2]});
    chk("ifid_valid",  {31'd0, bus.ifid_valid}, {31'd0, e_valid});
    chk("ifid_instr",  bus.ifid_instr,         e_instr);
    chk("ifid_pc4",    bus.ifid_pc4,           e_pc4);
    chk("fetch_count", bus.fetch_count,        m_cnt);
    $display("step rst=%0b stall=%0b redir=%0b tgt=%h -> pc=%h instr=%h pc4=%h v=%0b cnt=%0d",
             rs, s, r, tgt, bus.pc, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid, bus.fetch_count);
  endtask

  task automatic seq();
    step(1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 32'd0;

    // 1. reset for two cycles, then run
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("rst_pc",    bus.pc,          32'h0000_3000);
    chk("rst_instr", bus.ifid_instr,  32'h0000_0000);
    chk("rst_cnt",   bus.fetch_count, 32'd0);
    seq();
    chk("e1_instr", bus.ifid_instr,  32'h2008_0005);
    chk("e1_pc4",   bus.ifid_pc4,    32'h0000_3004);
    chk("e1_pc",    bus.pc,          32'h0000_3004);
    chk("e1_valid", {31'd0, bus.ifid_valid}, 32'd1);
    chk("e1_cnt",   bus.fetch_count, 32'd1);
    seq();
    chk("e2_instr", bus.ifid_instr,  32'h2009_0003);
    chk("e2_cnt",   bus.fetch_count, 32'd2);

    // 2. three stalled cycles at pc=3008, then release
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("stall_pc",  bus.pc,          32'h0000_3008);
    chk("stall_cnt", bus.fetch_count, 32'd2);
    seq();
    chk("rel_instr", bus.ifid_instr, mem[2]);
    chk("rel_pc",    bus.pc,         32'h0000_300C);

    // 3. redirect to 3040
    step(1'b0, 1'b1, 32'h0000_3040, 1'b0);
    chk("rd_pc",    bus.pc,          32'h0000_3040);
    chk("rd_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("rd_cnt",   bus.fetch_count, 32'd3);
    seq();
    chk("rd_instr", bus.ifid_instr, mem[16]);
    chk("rd_pc4",   bus.ifid_pc4,   32'h0000_3044);

    // 4. stall wins over redirect; misaligned target forced to word
    step(1'b1, 1'b1, 32'h0000_3100, 1'b0);
    chk("col_pc",    bus.pc, 32'h0000_3044);
    chk("col_valid", {31'd0, bus.ifid_valid}, 32'd1);
    step(1'b0, 1'b1, 32'h0000_3100, 1'b0);
    chk("col_rd_pc", bus.pc, 32'h0000_3100);
    seq();
    step(1'b0, 1'b1, 32'h0000_3103, 1'b0);
    chk("mis_pc", bus.pc, 32'h0000_3100);
    step(1'b0, 1'b1, 32'h0000_3100, 1'b0);
    chk("self_pc", bus.pc, 32'h0000_3100);
    seq();

    // 5. 4 KB window wrap
    step(1'b0, 1'b1, 32'h0000_3FFC, 1'b0);
    chk("wr_addr0", {22'd0, bus.im_addr}, 32'h0000_03FF);
    seq();
    chk("wr_addr1", {22'd0, bus.im_addr}, 32'h0000_0000);
    chk("wr_pc",    bus.pc,       32'h0000_4000);
    chk("wr_pc4",   bus.ifid_pc4, 32'h0000_4000);
    seq();

    // full 32-bit PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    seq();
    chk("pcwrap_pc",  bus.pc,       32'h0000_0000);
    chk("pcwrap_pc4", bus.ifid_pc4, 32'h0000_0000);

    // 6. reset mid-run, coincident with redirect
    for (int i = 0; i < 5; i++) seq();
    step(1'b0, 1'b1, 32'h0000_3200, 1'b1);
    chk("mr_pc",    bus.pc,          32'h0000_3000);
    chk("mr_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("mr_instr", bus.ifid_instr,  32'h0000_0000);
    chk("mr_cnt",   bus.fetch_count, 32'd0);
    seq();
    chk("post_instr", bus.ifid_instr, 32'h2008_0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
